// File: rtl/summ_seq_ctrl.sv
// Beamforming channel-summer sequencer: per focal point clears the summer, fetches one delayed
// sample per channel, closes the sum and hands the pixel downstream. Optional: CHANNEL_MASK_EN.
module summ_seq_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_PIXELS   = 64,
  parameter int SUM_WIDTH    = DATA_WIDTH + $clog2(NUM_CHANNELS),
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int PIX_W        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef CHANNEL_MASK_EN
  input  logic [NUM_CHANNELS-1:0] channel_mask,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  ch_req_valid,
  input  logic                  ch_req_ready,
  output logic [CH_W-1:0]       ch_idx,
  output logic [PIX_W-1:0]      pix_idx,
  input  logic                  ch_rsp_valid,
  input  logic [DATA_WIDTH-1:0] ch_rsp_data,
  output logic                  start_sum,
  output logic                  sum_en,
  output logic [DATA_WIDTH-1:0] delayed_sample,
  output logic                  done_channel,
  input  logic [SUM_WIDTH-1:0]  sum_result,
  input  logic                  sum_valid,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [SUM_WIDTH-1:0]  pix_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_REQ, S_WAIT, S_ACC, S_FLUSH, S_COLLECT, S_OUTPUT, S_DONE
  } state_t;

  state_t state;
  int     nxt_ch;

`ifdef CHANNEL_MASK_EN
  logic [NUM_CHANNELS-1:0] ch_mask;
`else
  localparam logic [NUM_CHANNELS-1:0] ch_mask = '1;
`endif

  // Lowest enabled channel at or above 'from'; NUM_CHANNELS when none is left.
  function automatic int next_en(input logic [NUM_CHANNELS-1:0] m, input int from);
    int r;
    r = NUM_CHANNELS;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (i >= from && m[i]) r = i;
    return r;
  endfunction

  always_comb nxt_ch = next_en(ch_mask, (state == S_ACC) ? int'(ch_idx) + 1 : 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      ch_req_valid   <= 1'b0;
      ch_idx         <= '0;
      pix_idx        <= '0;
      start_sum      <= 1'b0;
      sum_en         <= 1'b0;
      delayed_sample <= '0;
      done_channel   <= 1'b0;
      pix_valid      <= 1'b0;
      pix_data       <= '0;
`ifdef CHANNEL_MASK_EN
      ch_mask        <= '0;
`endif
    end else begin
      start_sum    <= 1'b0;
      sum_en       <= 1'b0;
      done_channel <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            busy      <= 1'b1;
            pix_idx   <= '0;
            start_sum <= 1'b1;
`ifdef CHANNEL_MASK_EN
            ch_mask   <= channel_mask;
`endif
          end
        end
        // CLEAR and ACC both pick the next enabled channel, or close the sum if none remain.
        S_CLEAR, S_ACC: begin
          if (nxt_ch == NUM_CHANNELS) begin
            state        <= S_FLUSH;
            done_channel <= 1'b1;
            if (state == S_CLEAR) ch_idx <= '0;
          end else begin
            state        <= S_REQ;
            ch_idx       <= CH_W'(nxt_ch);
            ch_req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (ch_req_ready) begin
            ch_req_valid <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ch_rsp_valid) begin
            sum_en         <= 1'b1;
            delayed_sample <= ch_rsp_data;
            state          <= S_ACC;
          end
        end
        S_FLUSH: state <= S_COLLECT;
        S_COLLECT: begin
          if (sum_valid) begin
            pix_data  <= sum_result;
            pix_valid <= 1'b1;
            state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (pix_idx == PIX_W'(NUM_PIXELS - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              pix_idx   <= pix_idx + 1'b1;
              state     <= S_CLEAR;
              start_sum <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_summ_seq_ctrl.sv
// Bench for summ_seq_ctrl: directed frames plus randomized handshakes, checked against a
// request/sum model built from the frame rules; emulates the delay unit and the summer.
`define CHK(tag, obs, exp) \
  begin \
    vectors++; \
    assert ((obs) === (exp)) else begin \
      miscompares++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

module tb_summ_seq_ctrl;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int NP = 2;
  localparam int SW = DW + $clog2(NC);
  localparam int CW = 2;
  localparam int PW = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NC-1:0] channel_mask = '1;
  logic          busy, done, ch_req_valid, start_sum, sum_en, done_channel, pix_valid;
  logic          ch_req_ready = 1'b0, ch_rsp_valid = 1'b0, sum_valid = 1'b0, pix_ready = 1'b0;
  logic [CW-1:0] ch_idx;
  logic [PW-1:0] pix_idx;
  logic [DW-1:0] ch_rsp_data = '0, delayed_sample;
  logic [SW-1:0] sum_result = '0, pix_data;

  summ_seq_ctrl #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .NUM_PIXELS(NP)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef CHANNEL_MASK_EN
    .channel_mask(channel_mask),
`endif
    .busy(busy), .done(done),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_idx(ch_idx), .pix_idx(pix_idx),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data),
    .start_sum(start_sum), .sum_en(sum_en), .delayed_sample(delayed_sample),
    .done_channel(done_channel), .sum_result(sum_result), .sum_valid(sum_valid),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [PW-1:0] p; logic [CW-1:0] c; } req_t;

  int            vectors = 0, miscompares = 0;
  bit            directed, junk_start, rst_in_wait, abort, start_pulse;
  int            stall_ch2, stall_out;
  req_t          exp_req[$];
  logic [DW-1:0] sum_q[$];
  logic [SW-1:0] pix_sum[NP], got_pix[NP];
  int            exp_pix, done_cnt;
  bit            pend;
  int            pend_dly;
  logic [PW-1:0] pend_p;
  logic [CW-1:0] pend_c;
  logic [SW-1:0] acc;
  bit            sv_arm;
  int            sv_wait;
  bit            prev_req_stall, prev_out_stall;
  logic [CW-1:0] prev_ch;
  logic [PW-1:0] prev_pix, prev_opix;
  logic [SW-1:0] prev_pdata;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      vectors++;
      if ((int'(start_sum) + int'(sum_en) + int'(done_channel)) > 1) begin
        miscompares++;
        $error("FAIL mon_pulse_exclusive: start_sum %0b sum_en %0b done_channel %0b",
               start_sum, sum_en, done_channel);
      end
      vectors++;
      if (done === 1'b1 && busy !== 1'b1) begin
        miscompares++;
        $error("FAIL mon_done_while_busy: done %0b busy %0b", done, busy);
      end
    end
  end

  function automatic logic [DW-1:0] dir_data(input int p, input int c);
    return DW'((c + 1) * ((p == 0) ? 1 : 10));
  endfunction

  task automatic model_reset();
    exp_req.delete(); sum_q.delete();
    pend = 0; sv_arm = 0; acc = '0; abort = 0;
    prev_req_stall = 0; prev_out_stall = 0;
    ch_req_ready = 1'b0; ch_rsp_valid = 1'b0; sum_valid = 1'b0; pix_ready = 1'b0; start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    `CHK(tag, {busy, done, ch_req_valid, ch_idx, pix_idx, start_sum, sum_en, delayed_sample,
               done_channel, pix_valid, pix_data}, 44'h0)
  endtask

  task automatic cycle();
    logic [DW-1:0] d;
    req_t r;
    @(negedge clk);
    if (start_sum | sum_en | done_channel)
      `CHK("pulse_exclusive", int'(start_sum) + int'(sum_en) + int'(done_channel), 1)
    if (pix_valid) `CHK("no_clear_during_output", start_sum, 1'b0)
    if (start_sum) begin acc = '0; sv_arm = 0; sum_valid = 1'b0; end
    if (sum_en) begin
      if (sum_q.size() == 0) `CHK("sum_en_without_sample", sum_q.size(), 1)
      else begin
        d = sum_q.pop_front();
        `CHK("delayed_sample", delayed_sample, d)
      end
      acc = acc + SW'(delayed_sample);
    end
    if (done_channel) begin sv_arm = 1; sv_wait = directed ? 0 : $urandom_range(0, 2); end
    if (sv_arm) begin
      if (sv_wait == 0) begin sum_valid = 1'b1; sum_result = acc; sv_arm = 0; end
      else sv_wait--;
    end
    if (prev_req_stall) begin
      `CHK("req_hold_valid", ch_req_valid, 1'b1)
      `CHK("req_hold_ch", ch_idx, prev_ch)
      `CHK("req_hold_pix", pix_idx, prev_pix)
    end
    ch_rsp_valid = 1'b0;
    if (pend) begin
      if (pend_dly == 0) begin
        d = directed ? dir_data(int'(pend_p), int'(pend_c)) : DW'($urandom);
        ch_rsp_valid = 1'b1; ch_rsp_data = d;
        sum_q.push_back(d);
        pix_sum[pend_p] = pix_sum[pend_p] + SW'(d);
        pend = 0;
      end else pend_dly--;
    end else if (!directed && $urandom_range(0, 7) == 0) begin
      ch_rsp_valid = 1'b1; ch_rsp_data = DW'($urandom);
    end
    if (rst_in_wait && pend && pend_p == 1'b1) abort = 1;
    ch_req_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (ch_req_valid && ch_idx == 2'd2 && stall_ch2 > 0) begin ch_req_ready = 1'b0; stall_ch2--; end
    if (ch_req_valid && ch_req_ready) begin
      if (exp_req.size() == 0) `CHK("req_unexpected", exp_req.size(), 1)
      else begin
        r = exp_req.pop_front();
        `CHK("req_ch", ch_idx, r.c)
        `CHK("req_pix", pix_idx, r.p)
      end
      pend = 1; pend_dly = directed ? 0 : $urandom_range(0, 2);
      pend_p = pix_idx; pend_c = ch_idx;
    end
    prev_req_stall = ch_req_valid && !ch_req_ready;
    prev_ch = ch_idx; prev_pix = pix_idx;
    if (prev_out_stall) begin
      `CHK("pix_hold_valid", pix_valid, 1'b1)
      `CHK("pix_hold_data", pix_data, prev_pdata)
      `CHK("pix_hold_idx", pix_idx, prev_opix)
    end
    pix_ready = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (pix_valid && stall_out > 0) begin pix_ready = 1'b0; stall_out--; end
    if (pix_valid && pix_ready) begin
      if (exp_pix >= NP) `CHK("pix_extra", exp_pix, NP - 1)
      else begin
        `CHK("pix_idx", pix_idx, PW'(exp_pix))
        `CHK("pix_data", pix_data, pix_sum[exp_pix])
        got_pix[exp_pix] = pix_data;
      end
      exp_pix++;
    end
    prev_out_stall = pix_valid && !pix_ready;
    prev_opix = pix_idx; prev_pdata = pix_data;
    if (done) begin
      done_cnt++;
      `CHK("done_after_last_pixel", exp_pix, NP)
    end
    start = start_pulse; start_pulse = 0;
    if (junk_start && busy && $urandom_range(0, 5) == 0) start = 1'b1;
    if (junk_start && done) start = 1'b1;
  endtask

  task automatic run_frame(input logic [NC-1:0] m);
    int n;
    exp_req.delete();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < NC; c++)
        if (m[c]) exp_req.push_back('{p: PW'(p), c: CW'(c)});
    for (int p = 0; p < NP; p++) begin pix_sum[p] = '0; got_pix[p] = '1; end
    exp_pix = 0; done_cnt = 0; abort = 0;
    channel_mask = m;
    start_pulse = 1;
    cycle();
    cycle();
    `CHK("busy_after_start", busy, 1'b1)
`ifdef CHANNEL_MASK_EN
    channel_mask = NC'($urandom);
`endif
    n = 0;
    while (done_cnt == 0 && !abort && n < 3000) begin cycle(); n++; end
    if (abort) return;
    `CHK("frame_completes", n < 3000, 1'b1)
    repeat (4) cycle();
    `CHK("busy_dropped", busy, 1'b0)
    `CHK("single_done", done_cnt, 1)
    `CHK("all_requests_issued", exp_req.size(), 0)
    `CHK("all_samples_summed", sum_q.size(), 0)
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    directed = 1; junk_start = 0; rst_in_wait = 0; stall_ch2 = 0; stall_out = 0; start_pulse = 0;
    #1 reset = 1'b0;
    #1 check_outputs_zero("reset_outputs");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // basic frame: 1+2+3+4 and 10+20+30+40
    run_frame('1);
    `CHK("t1_pix0", got_pix[0], SW'(10))
    `CHK("t1_pix1", got_pix[1], SW'(100))

    // request stalled on channel 2
    stall_ch2 = 5;
    run_frame('1);
    `CHK("t2_stall_used", stall_ch2, 0)
    `CHK("t2_pix0", got_pix[0], SW'(10))

    // downstream stall
    stall_out = 8;
    run_frame('1);
    `CHK("t3_stall_used", stall_out, 0)
    `CHK("t3_pix1", got_pix[1], SW'(100))

    // random data and handshakes, starts while busy and in DONE
    directed = 0; junk_start = 1;
    run_frame('1);
    junk_start = 0;
    repeat (6) run_frame('1);

    // reset while waiting for a sample of pixel 1
    rst_in_wait = 1;
    run_frame('1);
    `CHK("t5_reached_wait", abort, 1'b1)
    #2 reset = 1'b0;
    #1 check_outputs_zero("t5_async_reset");
    model_reset();
    rst_in_wait = 0;
    @(negedge clk);
    reset = 1'b1;
    directed = 1;
    run_frame('1);
    `CHK("t5_pix0", got_pix[0], SW'(10))
    `CHK("t5_pix1", got_pix[1], SW'(100))

`ifdef CHANNEL_MASK_EN
    run_frame(4'b0101);
    `CHK("t6_mask_pix0", got_pix[0], SW'(4))
    `CHK("t6_mask_pix1", got_pix[1], SW'(40))
    run_frame(4'b0000);
    `CHK("t6_zero_pix0", got_pix[0], SW'(0))
    `CHK("t6_zero_pix1", got_pix[1], SW'(0))
    directed = 0;
    repeat (4) run_frame(NC'($urandom));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
